uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- Serial receiver for the single-line RS232-like link driven by the team's UART transmitter.
- Decodes each frame (start bit, data MSB first, optional parity, stop bits) into a parallel word.
- Emits a one-cycle valid strobe with parity and framing status.
- Sits between the board RX pin and the command/readout logic of the sigma-delta ADC example.

Parameters:
C_CLK_FRQ, 100_000_000, clk frequency [Hz].
C_UART_RATE, 1_000_000, bit rate [baud]; C_PERIOD = C_CLK_FRQ / C_UART_RATE (integer, >= 4).
C_UART_DATA_WIDTH, 8, data bits per frame.
C_UART_PARITY, 1, 1 = parity bit present after the data, 0 = no parity bit.
C_UART_STOP, 1, number of stop bits checked {0, 1, 2}.

Ports:
clk  input  1  master clock.
rstb  input  1  reset, synchronous, active-low.
rx  input  1  asynchronous serial line, idle high.
data  output  C_UART_DATA_WIDTH  last received word.
valid  output  1  one-cycle strobe: data/parity_err/frame_err updated.
parity_err  output  1  last frame failed parity (always 0 if C_UART_PARITY = 0).
frame_err  output  1  last frame had a low stop bit.
busy  output  1  frame reception in progress.

Behaviour:
- rx passes through a 2-FF synchronizer (both FFs reset/init to 1); rx_s is the second FF. All decisions use rx_s.
- Reset (rstb low at clk edge): state = IDLE, data = 0, valid = 0, parity_err = 0, frame_err = 0, busy = 0, armed = 0.
- Reset mid-frame aborts the frame; no valid is produced for it.
- armed flag: set whenever rx_s == 1 in IDLE; cleared on leaving IDLE. A start is accepted only when armed. A line held low (break, or reset mid-frame) therefore never retriggers.
- Bit counter cnt (width $clog2(C_PERIOD)+1) and bit index idx.
- States:
  - IDLE: armed && rx_s == 0 -> START; cnt = 1.
  - START: at cnt == C_PERIOD/2, sample rx_s. 1 -> glitch, return to IDLE with no outputs. 0 -> DATA, cnt = 1, idx = 0.
  - DATA: at cnt == C_PERIOD, sample. shreg <= {shreg[W-2:0], rx_s} (first received bit ends as MSB); cnt = 1; idx++. After bit W-1 -> PARITY if C_UART_PARITY, else STOP if C_UART_STOP > 0, else DONE.
  - PARITY: at cnt == C_PERIOD, perr = rx_s ^ (^shreg), i.e. even parity: the parity bit equals the XOR of the data bits. Then -> STOP, or -> DONE if C_UART_STOP == 0.
  - STOP: sample each stop bit at cnt == C_PERIOD; any 0 sets ferr. After C_UART_STOP bits -> DONE.
  - DONE (one cycle): data <= shreg, parity_err <= perr, frame_err <= ferr, valid <= 1; -> IDLE.
- Outputs are registered. valid is high exactly one cycle, one cycle after the DONE state is entered.
- data and both error flags hold until the next valid.
- perr and ferr are cleared on entering START.
- Sampling points: centre of each bit, referenced to the synchronized falling edge.
- Total latency from the rx falling edge to valid: 2 (sync) + C_PERIOD/2 + (W + P + S)·C_PERIOD + 2 cycles.
- busy = 1 in every state except IDLE, and it is registered. busy falls in the same cycle valid rises.
- On a false start, busy falls with no valid.
- Frame with a low stop bit: word is still delivered with frame_err = 1.
- After a frame error, the receiver waits for rx_s high (armed) before the next start.
- Back-to-back frames with no idle gap are supported when C_UART_STOP >= 1.
- With C_UART_STOP = 0, the next start must be preceded by at least one high sample.
- Tolerates a ±3% baud mismatch for W = 8 with parity.

Test Plan:
- Default params, C_PERIOD = 100. Drive frame 0xA5 (line 0,1,0,1,0,0,1,0,1,0 parity,1 stop) -> single valid pulse, data = 0xA5, parity_err = 0, frame_err = 0; busy high for the whole frame.
- Same frame with parity bit = 1 -> data = 0xA5, parity_err = 1, frame_err = 0. Then a clean 0x3C frame -> parity_err returns to 0.
- 0x81 with stop bit driven 0, then line high -> data = 0x81, frame_err = 1. Next 0x42 frame is received cleanly once rx returns high.
- rx low pulse of 30 cycles -> busy pulses high then low, no valid, data unchanged. Hold rx low 5000 cycles -> at most one frame decoded (0x00, frame_err = 1), no retrigger.
- Back-to-back 0x00 then 0xFF with no gap -> two valid pulses exactly 11·C_PERIOD apart, correct data.
- rstb asserted mid-data-bit 4, released while the frame continues -> outputs zeroed, no valid for the aborted frame. Next full frame after a ≥1-bit idle is decoded.
- Loopback against the UART transmitter for all 256 words at C_PARITY ∈ {0,1} and C_STOP ∈ {1,2}, with rate skews of ±3% -> every word matches and no error flags are raised.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: receives start / MSB-first data / optional even parity / stop-bit frames
// from a single idle-high serial line and delivers each as a parallel word with status.
module uart_rx #(
  parameter int unsigned C_CLK_FRQ         = 100_000_000,
  parameter int unsigned C_UART_RATE       = 1_000_000,
  parameter int unsigned C_UART_DATA_WIDTH = 8,
  parameter int unsigned C_UART_PARITY     = 1,
  parameter int unsigned C_UART_STOP       = 1
) (
  input  logic                         clk,
  input  logic                         rstb,
  input  logic                         rx,
  output logic [C_UART_DATA_WIDTH-1:0] data,
  output logic                         valid,
  output logic                         parity_err,
  output logic                         frame_err,
  output logic                         busy
);

  localparam int unsigned C_PERIOD = C_CLK_FRQ / C_UART_RATE;
  localparam int unsigned W        = C_UART_DATA_WIDTH;
  localparam int unsigned CW       = $clog2(C_PERIOD) + 1;
  localparam int unsigned IW       = $clog2(W) + 1;

  localparam logic [CW-1:0] CNT_HALF      = CW'(C_PERIOD / 2);
  localparam logic [CW-1:0] CNT_FULL      = CW'(C_PERIOD);
  localparam logic [IW-1:0] IDX_LAST_DATA = IW'(W - 1);
  localparam logic [IW-1:0] IDX_LAST_STOP = IW'(C_UART_STOP - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    DONE
  } state_t;

  state_t          state, state_nxt;
  logic            rx_m, rx_s;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [IW-1:0]   idx, idx_nxt;
  logic [W-1:0]    shreg, shreg_nxt;
  logic            perr, perr_nxt;
  logic            ferr, ferr_nxt;
  logic            armed, armed_nxt;
  logic [W-1:0]    data_nxt;
  logic            valid_nxt;
  logic            parity_err_nxt;
  logic            frame_err_nxt;
  logic            busy_nxt;

  // Two-stage synchronizer for the asynchronous line; idles high out of reset.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      shreg      <= '0;
      perr       <= 1'b0;
      ferr       <= 1'b0;
      armed      <= 1'b0;
      data       <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      idx        <= idx_nxt;
      shreg      <= shreg_nxt;
      perr       <= perr_nxt;
      ferr       <= ferr_nxt;
      armed      <= armed_nxt;
      data       <= data_nxt;
      valid      <= valid_nxt;
      parity_err <= parity_err_nxt;
      frame_err  <= frame_err_nxt;
      busy       <= busy_nxt;
    end
  end

  // Frame sequencing: mid-bit sampling timed from the synchronized falling edge.
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    idx_nxt        = idx;
    shreg_nxt      = shreg;
    perr_nxt       = perr;
    ferr_nxt       = ferr;
    armed_nxt      = armed;
    data_nxt       = data;
    valid_nxt      = 1'b0;
    parity_err_nxt = parity_err;
    frame_err_nxt  = frame_err;

    case (state)
      IDLE: begin
        if (rx_s) begin
          armed_nxt = 1'b1;
        end else if (armed) begin
          state_nxt = START;
          cnt_nxt   = CW'(1);
          armed_nxt = 1'b0;
          perr_nxt  = 1'b0;
          ferr_nxt  = 1'b0;
        end
      end

      START: begin
        if (cnt == CNT_HALF) begin
          if (rx_s) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = DATA;
            cnt_nxt   = CW'(1);
            idx_nxt   = '0;
          end
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end

      DATA: begin
        if (cnt == CNT_FULL) begin
          shreg_nxt = W'({shreg, rx_s});
          cnt_nxt   = CW'(1);
          idx_nxt   = idx + IW'(1);
          if (idx == IDX_LAST_DATA) begin
            idx_nxt = '0;
            if (C_UART_PARITY != 0) begin
              state_nxt = PARITY;
            end else if (C_UART_STOP != 0) begin
              state_nxt = STOP;
            end else begin
              state_nxt = DONE;
            end
          end
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end

      PARITY: begin
        if (cnt == CNT_FULL) begin
          perr_nxt  = rx_s ^ (^shreg);
          cnt_nxt   = CW'(1);
          idx_nxt   = '0;
          state_nxt = (C_UART_STOP != 0) ? STOP : DONE;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end

      STOP: begin
        if (cnt == CNT_FULL) begin
          if (!rx_s) begin
            ferr_nxt = 1'b1;
          end
          cnt_nxt = CW'(1);
          if (idx == IDX_LAST_STOP) begin
            state_nxt = DONE;
          end else begin
            idx_nxt = idx + IW'(1);
          end
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end

      DONE: begin
        data_nxt       = shreg;
        parity_err_nxt = perr;
        frame_err_nxt  = ferr;
        valid_nxt      = 1'b1;
        state_nxt      = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx; one 8E1 instance at 100 clk/bit and one
// 8N2 instance at 16 clk/bit, each on its own line.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int unsigned P0 = 100;
  localparam int unsigned P1 = 16;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  logic       clk = 1'b0;
  logic       rstb;
  logic       rx0, rx1;
  logic [7:0] data0, data1;
  logic       valid0, perr0, ferr0, busy0;
  logic       valid1, perr1, ferr1, busy1;

  uart_rx #(
    .C_CLK_FRQ(100_000_000), .C_UART_RATE(1_000_000), .C_UART_DATA_WIDTH(8),
    .C_UART_PARITY(1), .C_UART_STOP(1)
  ) u0 (
    .clk(clk), .rstb(rstb), .rx(rx0), .data(data0), .valid(valid0),
    .parity_err(perr0), .frame_err(ferr0), .busy(busy0)
  );

  uart_rx #(
    .C_CLK_FRQ(1_600_000), .C_UART_RATE(100_000), .C_UART_DATA_WIDTH(8),
    .C_UART_PARITY(0), .C_UART_STOP(2)
  ) u1 (
    .clk(clk), .rstb(rstb), .rx(rx1), .data(data1), .valid(valid1),
    .parity_err(perr1), .frame_err(ferr1), .busy(busy1)
  );

  always #5 clk = ~clk;

  int   n_total = 0;
  int   n_bad   = 0;
  int   cyc     = 0;
  exp_t sb0[$];
  exp_t sb1[$];
  int   nvalid0 = 0;
  int   nvalid1 = 0;
  int   t_prev0 = 0;
  int   t_last0 = 0;
  logic pv0 = 1'b0, pb0 = 1'b0, pv1 = 1'b0, pb1 = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Compare one delivered word against the oldest expectation for that line.
  task automatic score(input int ln, input logic [7:0] d, input logic pe, input logic fe,
                       input logic vld, input logic bsy, input logic pv, input logic pb);
    exp_t e;
    chk($sformatf("valid_one_cycle%0d", ln), 32'(pv), 32'(0));
    chk($sformatf("busy_low_at_valid%0d", ln), 32'(bsy), 32'(0));
    chk($sformatf("busy_high_before_valid%0d", ln), 32'(pb), 32'(1));
    if ((ln == 0 && sb0.size() == 0) || (ln == 1 && sb1.size() == 0)) begin
      chk($sformatf("unexpected_valid%0d", ln), 32'(vld), 32'(0));
    end else begin
      if (ln == 0) e = sb0.pop_front();
      else         e = sb1.pop_front();
      chk($sformatf("data%0d", ln), 32'(d), 32'(e.d));
      chk($sformatf("parity_err%0d", ln), 32'(pe), 32'(e.pe));
      chk($sformatf("frame_err%0d", ln), 32'(fe), 32'(e.fe));
    end
  endtask

  always @(negedge clk) begin
    if (valid0) begin
      nvalid0++;
      t_prev0 = t_last0;
      t_last0 = cyc;
      score(0, data0, perr0, ferr0, valid0, busy0, pv0, pb0);
    end
    pv0 = valid0;
    pb0 = busy0;
  end

  always @(negedge clk) begin
    if (valid1) begin
      nvalid1++;
      score(1, data1, perr1, ferr1, valid1, busy1, pv1, pb1);
    end
    pv1 = valid1;
    pb1 = busy1;
  end

  task automatic set_rx(input int ln, input logic v);
    if (ln == 0) rx0 = v;
    else         rx1 = v;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive one frame and push its expected result; stop_low marks stop bits driven 0.
  task automatic send(input int ln, input logic [7:0] d, input int bitc, input bit par_en,
                      input bit par_flip, input int nstop, input logic [1:0] stop_low,
                      input bit chk_busy);
    logic lv [12];
    int   nb;
    exp_t e;
    lv[0] = 1'b0;
    for (int i = 0; i < 8; i++) lv[1 + i] = d[7 - i];
    nb = 9;
    if (par_en) begin
      lv[nb] = (^d) ^ par_flip;
      nb++;
    end
    e.d  = d;
    e.pe = par_en & par_flip;
    e.fe = 1'b0;
    for (int s = 0; s < nstop; s++) begin
      lv[nb] = ~stop_low[s];
      if (stop_low[s]) e.fe = 1'b1;
      nb++;
    end
    if (ln == 0) sb0.push_back(e);
    else         sb1.push_back(e);
    for (int b = 0; b < nb; b++) begin
      set_rx(ln, lv[b]);
      repeat (bitc / 2) @(negedge clk);
      if (chk_busy) chk($sformatf("busy_in_frame_bit%0d", b), 32'(busy0), 32'(1));
      repeat (bitc - bitc / 2) @(negedge clk);
    end
    set_rx(ln, 1'b1);
  endtask

  task automatic drain(input int ln, input int budget);
    int n;
    n = 0;
    while (((ln == 0) ? sb0.size() : sb1.size()) != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("pending_after_drain%0d", ln), 32'((ln == 0) ? sb0.size() : sb1.size()), 32'(0));
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog cyc=%0d expected_finish_before_limit", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int         nv;
    int         busy_hi;
    logic [7:0] w;
    logic [7:0] fr;

    rstb = 1'b0;
    rx0  = 1'b1;
    rx1  = 1'b1;
    idle(4);
    chk("rst_data0", 32'(data0), 32'(0));
    chk("rst_valid0", 32'(valid0), 32'(0));
    chk("rst_perr0", 32'(perr0), 32'(0));
    chk("rst_ferr0", 32'(ferr0), 32'(0));
    chk("rst_busy0", 32'(busy0), 32'(0));
    chk("rst_busy1", 32'(busy1), 32'(0));
    rstb = 1'b1;
    idle(20);

    // Clean frame, bad parity, then clean again.
    send(0, 8'hA5, P0, 1'b1, 1'b0, 1, 2'b00, 1'b1); drain(0, 300); idle(50);
    send(0, 8'hA5, P0, 1'b1, 1'b1, 1, 2'b00, 1'b1); drain(0, 300); idle(50);
    send(0, 8'h3C, P0, 1'b1, 1'b0, 1, 2'b00, 1'b1); drain(0, 300); idle(50);

    // Low stop bit, then recovery once the line is high.
    send(0, 8'h81, P0, 1'b1, 1'b0, 1, 2'b01, 1'b1); drain(0, 300); idle(100);
    send(0, 8'h42, P0, 1'b1, 1'b0, 1, 2'b00, 1'b1); drain(0, 300); idle(100);

    // 30-cycle low pulse: false start, busy for half a bit, no word.
    nv = nvalid0;
    busy_hi = 0;
    rx0 = 1'b0;
    repeat (30) begin @(negedge clk); if (busy0) busy_hi++; end
    rx0 = 1'b1;
    repeat (100) begin @(negedge clk); if (busy0) busy_hi++; end
    chk("glitch_busy_cycles", 32'(busy_hi), 32'(P0 / 2));
    chk("glitch_busy_end", 32'(busy0), 32'(0));
    chk("glitch_nvalid", 32'(nvalid0 - nv), 32'(0));
    chk("glitch_data_kept", 32'(data0), 32'(8'h42));

    // Break: one all-zero word with framing error, no retrigger.
    nv = nvalid0;
    sb0.push_back('{d: 8'h00, pe: 1'b0, fe: 1'b1});
    rx0 = 1'b0;
    idle(5000);
    rx0 = 1'b1;
    idle(200);
    chk("break_nvalid", 32'(nvalid0 - nv), 32'(1));
    drain(0, 10);

    // Back-to-back frames with no idle gap.
    send(0, 8'h00, P0, 1'b1, 1'b0, 1, 2'b00, 1'b1);
    send(0, 8'hFF, P0, 1'b1, 1'b0, 1, 2'b00, 1'b1);
    drain(0, 300);
    chk("b2b_gap", 32'(t_last0 - t_prev0), 32'(11 * P0));
    idle(100);

    // Reset in the middle of data bit 4 of 0x4F, released while the line stays high.
    nv = nvalid0;
    fr = 8'h4F;
    rx0 = 1'b0;
    idle(P0);
    for (int i = 0; i < 4; i++) begin
      rx0 = fr[7 - i];
      idle(P0);
    end
    rx0 = fr[3];
    idle(P0 / 2);
    rstb = 1'b0;
    idle(3);
    chk("abort_rst_data", 32'(data0), 32'(0));
    chk("abort_rst_valid", 32'(valid0), 32'(0));
    chk("abort_rst_perr", 32'(perr0), 32'(0));
    chk("abort_rst_ferr", 32'(ferr0), 32'(0));
    chk("abort_rst_busy", 32'(busy0), 32'(0));
    idle(57);
    rstb = 1'b1;
    idle(400);
    chk("abort_nvalid", 32'(nvalid0 - nv), 32'(0));
    chk("abort_busy_idle", 32'(busy0), 32'(0));
    send(0, 8'h96, P0, 1'b1, 1'b0, 1, 2'b00, 1'b1); drain(0, 300); idle(50);

    // Random words at +/-3% bit-rate skew, back-to-back.
    for (int i = 0; i < 20; i++) begin
      w = 8'($urandom_range(0, 255));
      send(0, w, (i % 2 == 1) ? 103 : 97, 1'b1, 1'b0, 1, 2'b00, 1'b0);
      drain(0, 400);
    end
    idle(100);

    // No-parity, two-stop-bit instance.
    for (int i = 0; i < 12; i++) begin
      w = 8'($urandom_range(0, 255));
      send(1, w, P1, 1'b0, 1'b0, 2, 2'b00, 1'b0);
      drain(1, 100);
    end
    send(1, 8'h5A, P1, 1'b0, 1'b0, 2, 2'b10, 1'b0); drain(1, 100); idle(40);
    send(1, 8'hC3, P1, 1'b0, 1'b0, 2, 2'b00, 1'b0); drain(1, 100); idle(40);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
